router_out_alloc: RTL
=====================

# router_out_alloc

Output-port allocator for one output of the 5-port, 2-VC wormhole router. It arbitrates the input ports whose head flit targets this output and locks each VC to one packet from head to tail. It tracks downstream buffer credits per VC and issues one flit transfer per cycle, with round-robin fairness across ports and across VCs. One instance sits at each router output, and it drives the crossbar select and the output valid/VC signals.

## Interface
- NPORT, 5, number of input ports (requesters)
- CREDITS, 4, downstream buffer depth per VC (credits at reset)
- CW, 3, credit counter width, must hold CREDITS
- clk  in  1  sole clock, rising edge
- RST_  in  1  reset, asynchronous, active-low
- REQ  in  NPORT  bit i: input port i holds a flit destined to this output
- REQ_VC  in  NPORT  bit i: VC of port i's flit (0/1)
- HEAD  in  NPORT  bit i: port i's flit is a head flit
- TAIL  in  NPORT  bit i: port i's flit is a tail flit (HEAD&TAIL = single-flit packet)
- IACK  in  2  per-VC credit return pulse from downstream, one credit per cycle per bit
- GNT  out  NPORT  one-hot, combinational: port i's flit transfers this cycle
- SEL  out  3  crossbar select = index of granted port (0 when idle)
- FIRE  out  1  a flit transfers this cycle (= |GNT)
- OVCH  out  1  VC of the transferring flit (0 when idle)
- OLCK  out  2  registered per-VC lock flags
- ERR  out  1  sticky credit-overflow flag

## Operation
- Per-VC state: lock flag, owner (3b), port pointer (3b), credit count (CW). Global state: VC pointer (1b), ERR.
- VC v is eligible in either of two cases:
  - Locked, the owner asserts REQ with REQ_VC==v, and credit[v]>0.
  - Unlocked, some port asserts REQ&HEAD with REQ_VC==v, and credit[v]>0.
- Non-head flits on an unlocked VC and non-owner requests on a locked VC are ignored and never granted.
- VC choice:
  - If both VCs are eligible, take VC = VC pointer; the VC pointer then toggles on FIRE.
  - If only one VC is eligible, take it; the VC pointer is set to the other VC.
- Port choice for a locked VC: the owner.
- Port choice for an unlocked VC: the first eligible head requester searching from pointer[v] upward, mod NPORT. On that grant, pointer[v] = winner+1 mod NPORT.
- Lock update on FIRE:
  - Head without tail on an unlocked VC: lock=1, owner=winner.
  - Tail on a locked VC: lock=0.
  - Head+tail: lock is unchanged (stays 0).
- Credit update: credit[v] − (FIRE&OVCH==v) + IACK[v]. A simultaneous fire and return on the same VC leaves it unchanged.
- Credit overflow: if the update would exceed CREDITS, hold the count at CREDITS and set ERR (sticky until reset).
- During reset (RST_=0), GNT, FIRE, SEL and OVCH are forced to 0.

## Timing
- Grant path is combinational: REQ/HEAD/TAIL/REQ_VC to GNT/SEL/FIRE/OVCH in the same cycle, based on registered lock, credit and pointer state.
- Lock, owner, pointers and credits update on the clk edge where FIRE is high. OLCK reflects the new lock the cycle after the head transfers.
- IACK at edge N becomes usable credit for a grant in cycle N+1.
- A VC at 0 credits blocks, even while locked. Other VC traffic proceeds.
- Tail and head on the same VC cannot transfer in the same cycle. The new head can win the cycle after the tail.
- Reset values, applied asynchronously:
  - OLCK=0, ERR=0.
  - credit[0..1]=CREDITS.
  - Owners, port pointers and the VC pointer = 0.
- Reset asserted mid-packet drops the lock immediately. No flit is granted until RST_ deasserts, and the first grant after deassertion is in the first full cycle.

## Test plan
- Single-flit packet: port 2 REQ=1, HEAD=TAIL=1, VC0 → same cycle GNT=5'b00100, SEL=2, OVCH=0; OLCK stays 0; credit0 3 next cycle.
- Port round-robin: ports 0, 1 and 3 request 1-flit VC0 packets continuously, with IACK0 returned every cycle → grant order 0,1,3,0,1,3; pointer wraps past port 4.
- Wormhole lock: port 1 sends a 4-flit VC1 packet while port 4 sends heads on VC1 →
  - port 4 is never granted until port 1's tail fires;
  - OLCK[1]=1 from the cycle after the head until the cycle after the tail;
  - port 4 is granted the next cycle.
- Credit stall: CREDITS=4, no IACK, a 6-flit VC0 packet → 4 flits fire, then FIRE=0. IACK0 pulse → 1 flit fires the following cycle. A simultaneous fire and IACK holds the count.
- VC interleave: locked packets on VC0 and VC1, both with credit → OVCH alternates 0,1,0,1. When VC1 credits hit 0, VC0 fires every cycle.
- Overflow and reset: IACK0 at full credit → ERR=1, credit stays 4. RST_ low mid-packet → OLCK=0, ERR=0, GNT=0 immediately.

Source files
------------

// File: rtl/router_out_alloc.sv
// Output-port allocator for one output of a 5-port, 2-VC wormhole router.
// Round-robin port/VC arbitration, per-VC packet locking and downstream credit tracking.
module router_out_alloc #(
   parameter int NPORT   = 5,
   parameter int CREDITS = 4,
   parameter int CW      = 3
) (
   input  logic             clk,
   input  logic             RST_,
   input  logic [NPORT-1:0] REQ,
   input  logic [NPORT-1:0] REQ_VC,
   input  logic [NPORT-1:0] HEAD,
   input  logic [NPORT-1:0] TAIL,
   input  logic [1:0]       IACK,
   output logic [NPORT-1:0] GNT,
   output logic [2:0]       SEL,
   output logic             FIRE,
   output logic             OVCH,
   output logic [1:0]       OLCK,
   output logic             ERR
);

   localparam logic [CW-1:0]    CRED_INIT = CREDITS[CW-1:0];
   localparam logic [CW:0]      CRED_MAX  = CREDITS[CW:0];
   localparam logic [NPORT-1:0] GNT_ONE   = {{(NPORT-1){1'b0}}, 1'b1};

   logic [1:0]       lock_r;
   logic [2:0]       owner_r   [2];
   logic [2:0]       ptr_r     [2];
   logic [CW-1:0]    credit_r  [2];
   logic             vcptr_r;
   logic             err_r;

   logic [NPORT-1:0] vc_mask_s  [2];
   logic [NPORT-1:0] head_req_s [2];
   logic [3:0]       pick_s     [2];
   logic [2:0]       win_s      [2];
   logic [1:0]       elig_s;
   logic             vc_s;
   logic             fire_s;
   logic [2:0]       port_s;
   logic [NPORT-1:0] gnt_s;
   logic [CW:0]      cred_sum_s [2];
   logic [1:0]       cred_ovf_s;

   // First set bit of mask at or above ptr (wrapping); returns {found, index}.
   function automatic logic [3:0] rr_pick(input logic [NPORT-1:0] mask, input logic [2:0] ptr);
      logic [3:0] pick;
      logic [3:0] sum;
      logic [2:0] idx;
      pick = 4'd0;
      for (int k = NPORT - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + 4'(k);
         idx = (sum >= 4'(NPORT)) ? 3'(sum - 4'(NPORT)) : sum[2:0];
         if (mask[idx]) begin
            pick = {1'b1, idx};
         end
      end
      return pick;
   endfunction

   function automatic logic [2:0] next_port(input logic [2:0] p);
      return (p == 3'(NPORT - 1)) ? 3'd0 : p + 3'd1;
   endfunction

   // Per-VC eligibility and candidate port: the owner when locked, else round-robin over heads.
   always_comb begin
      for (int v = 0; v < 2; v++) begin
         vc_mask_s[v]  = (v == 0) ? ~REQ_VC : REQ_VC;
         head_req_s[v] = REQ & HEAD & vc_mask_s[v];
         pick_s[v]     = rr_pick(head_req_s[v], ptr_r[v]);
         if (lock_r[v]) begin
            win_s[v]  = owner_r[v];
            elig_s[v] = REQ[owner_r[v]] & vc_mask_s[v][owner_r[v]] & (credit_r[v] != {CW{1'b0}});
         end else begin
            win_s[v]  = pick_s[v][2:0];
            elig_s[v] = pick_s[v][3] & (credit_r[v] != {CW{1'b0}});
         end
      end
   end

   // VC choice and the combinational grant, held off entirely while in reset.
   always_comb begin
      vc_s   = 1'b0;
      fire_s = 1'b0;
      if (!RST_) begin
         vc_s   = 1'b0;
         fire_s = 1'b0;
      end else if (elig_s == 2'b11) begin
         vc_s   = vcptr_r;
         fire_s = 1'b1;
      end else if (elig_s[1]) begin
         vc_s   = 1'b1;
         fire_s = 1'b1;
      end else if (elig_s[0]) begin
         vc_s   = 1'b0;
         fire_s = 1'b1;
      end else begin
         vc_s   = 1'b0;
         fire_s = 1'b0;
      end
      port_s = fire_s ? win_s[vc_s] : 3'd0;
      gnt_s  = fire_s ? (GNT_ONE << port_s) : {NPORT{1'b0}};
   end

   // Next credit count; a fired flit needs credit>0, so the subtraction cannot underflow.
   always_comb begin
      for (int v = 0; v < 2; v++) begin
         cred_sum_s[v] = {1'b0, credit_r[v]} + {{CW{1'b0}}, IACK[v]}
                       - {{CW{1'b0}}, (fire_s && (vc_s == v[0]))};
         cred_ovf_s[v] = (cred_sum_s[v] > CRED_MAX);
      end
   end

   // Lock, owner, pointer, credit and error state.
   always_ff @(posedge clk or negedge RST_) begin
      if (!RST_) begin
         lock_r  <= 2'b00;
         vcptr_r <= 1'b0;
         err_r   <= 1'b0;
         for (int v = 0; v < 2; v++) begin
            owner_r[v]  <= 3'd0;
            ptr_r[v]    <= 3'd0;
            credit_r[v] <= CRED_INIT;
         end
      end else begin
         for (int v = 0; v < 2; v++) begin
            credit_r[v] <= cred_ovf_s[v] ? CRED_INIT : cred_sum_s[v][CW-1:0];
         end
         if (|cred_ovf_s) begin
            err_r <= 1'b1;
         end
         if (fire_s) begin
            vcptr_r <= ~vc_s;
            if (lock_r[vc_s]) begin
               if (TAIL[port_s]) begin
                  lock_r[vc_s] <= 1'b0;
               end
            end else begin
               ptr_r[vc_s] <= next_port(port_s);
               if (HEAD[port_s] && !TAIL[port_s]) begin
                  lock_r[vc_s]  <= 1'b1;
                  owner_r[vc_s] <= port_s;
               end
            end
         end
      end
   end

   assign GNT  = gnt_s;
   assign SEL  = port_s;
   assign FIRE = fire_s;
   assign OVCH = vc_s;
   assign OLCK = lock_r;
   assign ERR  = err_r;

endmodule
